// File: rtl/spo2_ratio_calc.sv
// ============================================================================
// spo2_ratio_calc
//
// Purpose:
//   Tracks per-channel min/max of the RED and IR ADC streams over windows of
//   WIN_LEN samples. It derives AC = max-min and DC = (max+min)>>1 for each
//   channel, then computes the ratio
//      R = (AC_red * DC_ir) / (AC_ir * DC_red)
//   in unsigned Q4.8. A 24-step restoring divider does the division, one bit
//   per clock.
//
// Configuration:
//   SPO2_RATIO_MOVAVG_EN - when defined, Ratio is a 4-tap moving average of
//   the raw (saturated) quotients. This adds one cycle of latency.
//
// Ports:
//   CLK            in   1   clock, rising edge
//   rst_n          in   1   asynchronous active-low reset
//   sample_valid   in   1   strobe: both ADC inputs carry a new sample
//   RED_ADC_Value  in   8   RED sample, unsigned
//   IR_ADC_Value   in   8   IR sample, unsigned
//   RED_AC/RED_DC  out  8   RED AC/DC of the last closed window
//   IR_AC/IR_DC    out  8   IR AC/DC of the last closed window
//   Ratio          out  12  R in Q4.8, saturating at 12'hFFF
//   Ratio_valid    out  1   one-cycle pulse when Ratio updates
//   Busy           out  1   ratio computation in flight
//   Div_Zero       out  1   the denominator of the current Ratio was zero
//   Overrun        out  1   one-cycle pulse: a window closed while Busy
// ============================================================================
module spo2_ratio_calc #(
   parameter int WIN_LEN = 256
) (
   input  logic        CLK,
   input  logic        rst_n,
   input  logic        sample_valid,
   input  logic [7:0]  RED_ADC_Value,
   input  logic [7:0]  IR_ADC_Value,
   output logic [7:0]  RED_AC,
   output logic [7:0]  RED_DC,
   output logic [7:0]  IR_AC,
   output logic [7:0]  IR_DC,
   output logic [11:0] Ratio,
   output logic        Ratio_valid,
   output logic        Busy,
   output logic        Div_Zero,
   output logic        Overrun
);

   localparam logic [15:0] LAST_IDX = 16'(WIN_LEN - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_MULT,
      S_DIV,
      S_DONE,
      S_AVG
   } state_t;

   // ------------------------------------------------------------------------
   // Sample counter and window close detection
   // ------------------------------------------------------------------------
   logic [15:0] cnt_q, cnt_d;
   logic        first_smp;
   logic        win_close;

   assign first_smp = (cnt_q == 16'd0);
   assign win_close = sample_valid && (cnt_q == LAST_IDX);

   // ------------------------------------------------------------------------
   // Per-channel min/max trackers.
   // Channel 0 is RED and channel 1 is IR.
   // The *_d values already include the current sample. The close edge can
   // therefore load AC/DC straight from them.
   // ------------------------------------------------------------------------
   logic [1:0][7:0] samp;
   logic [1:0][7:0] ac_n;
   logic [1:0][7:0] dc_n;

   assign samp[0] = RED_ADC_Value;
   assign samp[1] = IR_ADC_Value;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_trk
         logic [7:0] min_q, min_d;
         logic [7:0] max_q, max_d;
         logic [8:0] sum;

         always_comb begin
            min_d = min_q;
            max_d = max_q;
            if (first_smp || (samp[gi] < min_q)) min_d = samp[gi];
            if (first_smp || (samp[gi] > max_q)) max_d = samp[gi];
         end

         // 9-bit sum so that (max+min) cannot overflow before the halving.
         assign sum      = {1'b0, max_d} + {1'b0, min_d};
         assign ac_n[gi] = max_d - min_d;
         assign dc_n[gi] = 8'(sum >> 1);

         always_ff @(posedge CLK or negedge rst_n) begin
            if (!rst_n) begin
               min_q <= '0;
               max_q <= '0;
            end else if (sample_valid) begin
               min_q <= min_d;
               max_q <= max_d;
            end
         end
      end
   endgenerate

   // ------------------------------------------------------------------------
   // Ratio datapath and control state
   // ------------------------------------------------------------------------
   state_t      state_q, state_d;
   logic [7:0]  red_ac_q, red_ac_d;
   logic [7:0]  red_dc_q, red_dc_d;
   logic [7:0]  ir_ac_q,  ir_ac_d;
   logic [7:0]  ir_dc_q,  ir_dc_d;
   logic [11:0] ratio_q, ratio_d;
   logic        ratio_valid_q, ratio_valid_d;
   logic        busy_q, busy_d;
   logic        div_zero_q, div_zero_d;
   logic        overrun_q, overrun_d;

   // During the division, num holds the remaining dividend bits and the
   // quotient bits are shifted in at the LSB. After 24 steps it holds the
   // whole quotient.
   logic [23:0] num_q, num_d;
   logic [15:0] den_q, den_d;
   logic [15:0] rem_q, rem_d;
   logic [4:0]  step_q, step_d;

   logic [15:0] prod_num;
   logic [15:0] prod_den;
   logic [16:0] rem_sh;
   logic [11:0] raw_ratio;
   logic        raw_dz;

   assign prod_num = 16'(red_ac_q) * 16'(ir_dc_q);
   assign prod_den = 16'(ir_ac_q)  * 16'(red_dc_q);
   assign rem_sh   = {rem_q, num_q[23]};

   // Saturated raw result. A zero denominator makes the restoring divider
   // produce all-ones, but the zero case is flagged explicitly anyway.
   always_comb begin
      raw_dz    = (den_q == 16'd0);
      raw_ratio = num_q[11:0];
      if (raw_dz || (|num_q[23:12])) raw_ratio = 12'hFFF;
   end

`ifdef SPO2_RATIO_MOVAVG_EN
   logic [3:0][11:0] tap_q, tap_d;
   logic             have_q, have_d;
   logic             dz_hold_q, dz_hold_d;
   logic [13:0]      tap_sum;

   assign tap_sum = 14'(tap_q[0]) + 14'(tap_q[1]) + 14'(tap_q[2]) + 14'(tap_q[3]);
`endif

   always_comb begin
      cnt_d         = cnt_q;
      state_d       = state_q;
      red_ac_d      = red_ac_q;
      red_dc_d      = red_dc_q;
      ir_ac_d       = ir_ac_q;
      ir_dc_d       = ir_dc_q;
      ratio_d       = ratio_q;
      ratio_valid_d = 1'b0;
      busy_d        = busy_q;
      div_zero_d    = div_zero_q;
      overrun_d     = 1'b0;
      num_d         = num_q;
      den_d         = den_q;
      rem_d         = rem_q;
      step_d        = step_q;
`ifdef SPO2_RATIO_MOVAVG_EN
      tap_d         = tap_q;
      have_d        = have_q;
      dz_hold_d     = dz_hold_q;
`endif

      if (sample_valid) cnt_d = win_close ? 16'd0 : cnt_q + 16'd1;

      // AC/DC always load on a close. A ratio starts only from IDLE. The
      // DONE (and AVG) cycle is still busy, so a close there is dropped.
      if (win_close) begin
         red_ac_d = ac_n[0];
         red_dc_d = dc_n[0];
         ir_ac_d  = ac_n[1];
         ir_dc_d  = dc_n[1];
         if (state_q == S_IDLE) begin
            state_d = S_MULT;
            busy_d  = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end

      case (state_q)
         S_MULT: begin
            num_d   = {prod_num, 8'h00};
            den_d   = prod_den;
            rem_d   = '0;
            step_d  = '0;
            state_d = S_DIV;
         end
         S_DIV: begin
            if (rem_sh >= {1'b0, den_q}) begin
               rem_d = 16'(rem_sh - {1'b0, den_q});
               num_d = {num_q[22:0], 1'b1};
            end else begin
               rem_d = rem_sh[15:0];
               num_d = {num_q[22:0], 1'b0};
            end
            step_d = step_q + 5'd1;
            if (step_q == 5'd23) state_d = S_DONE;
         end
         S_DONE: begin
`ifdef SPO2_RATIO_MOVAVG_EN
            // The first result after reset fills every tap, so the average
            // starts at the first quotient instead of ramping up from zero.
            if (!have_q) begin
               for (int k = 0; k < 4; k++) tap_d[k] = raw_ratio;
            end else begin
               tap_d = {tap_q[2:0], raw_ratio};
            end
            have_d    = 1'b1;
            dz_hold_d = raw_dz;
            state_d   = S_AVG;
`else
            ratio_d       = raw_ratio;
            div_zero_d    = raw_dz;
            ratio_valid_d = 1'b1;
            busy_d        = 1'b0;
            state_d       = S_IDLE;
`endif
         end
         S_AVG: begin
`ifdef SPO2_RATIO_MOVAVG_EN
            ratio_d       = 12'(tap_sum >> 2);
            div_zero_d    = dz_hold_q;
            ratio_valid_d = 1'b1;
            busy_d        = 1'b0;
`endif
            state_d = S_IDLE;
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q         <= '0;
         state_q       <= S_IDLE;
         red_ac_q      <= '0;
         red_dc_q      <= '0;
         ir_ac_q       <= '0;
         ir_dc_q       <= '0;
         ratio_q       <= '0;
         ratio_valid_q <= 1'b0;
         busy_q        <= 1'b0;
         div_zero_q    <= 1'b0;
         overrun_q     <= 1'b0;
         num_q         <= '0;
         den_q         <= '0;
         rem_q         <= '0;
         step_q        <= '0;
`ifdef SPO2_RATIO_MOVAVG_EN
         tap_q         <= '0;
         have_q        <= 1'b0;
         dz_hold_q     <= 1'b0;
`endif
      end else begin
         cnt_q         <= cnt_d;
         state_q       <= state_d;
         red_ac_q      <= red_ac_d;
         red_dc_q      <= red_dc_d;
         ir_ac_q       <= ir_ac_d;
         ir_dc_q       <= ir_dc_d;
         ratio_q       <= ratio_d;
         ratio_valid_q <= ratio_valid_d;
         busy_q        <= busy_d;
         div_zero_q    <= div_zero_d;
         overrun_q     <= overrun_d;
         num_q         <= num_d;
         den_q         <= den_d;
         rem_q         <= rem_d;
         step_q        <= step_d;
`ifdef SPO2_RATIO_MOVAVG_EN
         tap_q         <= tap_d;
         have_q        <= have_d;
         dz_hold_q     <= dz_hold_d;
`endif
      end
   end

   assign RED_AC      = red_ac_q;
   assign RED_DC      = red_dc_q;
   assign IR_AC       = ir_ac_q;
   assign IR_DC       = ir_dc_q;
   assign Ratio       = ratio_q;
   assign Ratio_valid = ratio_valid_q;
   assign Busy        = busy_q;
   assign Div_Zero    = div_zero_q;
   assign Overrun     = overrun_q;

endmodule
